// File: rtl/div_unit_pkg.sv
// -----------------------------------------------------------------------------
// div_unit_pkg
// Shared types and constants for the iterative RV32M divider.
//   div_op_t    : funct3[1:0] encoding of DIV / DIVU / REM / REMU
//   div_state_t : divider control states
//   XLEN        : operand/result width, also the number of restoring steps
// Helper functions decode the op and form operand magnitudes.
// -----------------------------------------------------------------------------
package div_unit_pkg;

    localparam int XLEN  = 32;
    localparam int CNT_W = $clog2(XLEN);

    localparam logic [XLEN-1:0]  ZERO_W   = {XLEN{1'b0}};
    localparam logic [XLEN-1:0]  ALL_ONES = {XLEN{1'b1}};
    localparam logic [XLEN-1:0]  MIN_INT  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_LAST = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        DIV  = 2'b00,
        DIVU = 2'b01,
        REM  = 2'b10,
        REMU = 2'b11
    } div_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        FIX  = 2'b10,
        DONE = 2'b11
    } div_state_t;

    // funct3[0]==0 selects the signed variants (DIV, REM).
    function automatic logic op_is_signed(input div_op_t op);
        return ~op[0];
    endfunction

    // funct3[1]==0 selects a quotient result (DIV, DIVU).
    function automatic logic op_is_quo(input div_op_t op);
        return ~op[1];
    endfunction

    // Magnitude of v when treated as signed; -MIN_INT wraps to MIN_INT,
    // which read unsigned is exactly 2^(XLEN-1).
    function automatic logic [XLEN-1:0] abs_if(input logic [XLEN-1:0] v,
                                               input logic            is_signed);
        return (is_signed && v[XLEN-1]) ? -v : v;
    endfunction

endpackage

// File: rtl/div_unit_if.sv
// -----------------------------------------------------------------------------
// div_unit_if
// Request/response bundle between the EX stage (master) and the divider
// (slave).
//   start  : request, master -> slave
//   op     : DIV/DIVU/REM/REMU, master -> slave
//   a, b   : dividend / divisor, master -> slave
//   busy   : divider occupied (RUN/FIX), slave -> master
//   done   : one-cycle completion pulse, slave -> master
//   result : quotient or remainder, slave -> master
// -----------------------------------------------------------------------------
interface div_unit_if;
    import div_unit_pkg::*;

    logic            start;
    div_op_t         op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    modport master (output start, op, a, b, input busy, done, result);
    modport slave  (input start, op, a, b, output busy, done, result);

endinterface

// File: rtl/div_unit_step.sv
// -----------------------------------------------------------------------------
// div_unit_step
// One combinational restoring-division step on unsigned magnitudes.
//   rem_in, quo_in : partial remainder and remaining dividend/quotient bits
//   divisor        : unsigned divisor magnitude
//   rem_out        : partial remainder after the trial subtraction
//   quo_out        : quo_in shifted left with the new quotient bit in bit 0
// -----------------------------------------------------------------------------
module div_unit_step
    import div_unit_pkg::*;
(
    input  logic [XLEN-1:0] rem_in,
    input  logic [XLEN-1:0] quo_in,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] rem_out,
    output logic [XLEN-1:0] quo_out
);

    logic [XLEN:0]   rem_shift;
    logic            fits;
    logic [XLEN-1:0] diff;

    // Shift {rem,quo} left by one and do the trial subtraction.
    always_comb begin
        rem_shift = {rem_in, quo_in[XLEN-1]};
        // The shifted remainder can exceed XLEN bits when the divisor is
        // large (DIVU), so the test is a full-width compare rather than the
        // sign of a narrow difference.
        fits      = (rem_shift >= {1'b0, divisor});
        // When it fits the true difference is below the divisor, so the
        // low XLEN bits of the modular difference are exact.
        diff      = rem_shift[XLEN-1:0] - divisor;
        if (fits) begin
            rem_out = diff;
            quo_out = {quo_in[XLEN-2:0], 1'b1};
        end else begin
            rem_out = rem_shift[XLEN-1:0];
            quo_out = {quo_in[XLEN-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/div_unit.sv
// -----------------------------------------------------------------------------
// div_unit
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// One quotient bit per cycle on operand magnitudes, then a sign fix-up.
//   clk   : rising-edge clock
//   reset : synchronous, active-high; aborts any operation in flight
//   bus   : div_unit_if slave (start/op/a/b in, busy/done/result out)
// Divide-by-zero and signed overflow complete on the accepting edge.
// busy, done and result are driven straight from flops.
// -----------------------------------------------------------------------------
module div_unit
    import div_unit_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    div_unit_if.slave  bus
);

    div_state_t       state_q,   state_d;
    div_op_t          op_q,      op_d;
    logic [XLEN-1:0]  rem_q,     rem_d;
    logic [XLEN-1:0]  quo_q,     quo_d;
    logic [XLEN-1:0]  divisor_q, divisor_d;
    logic             q_neg_q,   q_neg_d;
    logic             r_neg_q,   r_neg_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic [XLEN-1:0]  result_q,  result_d;
    logic             busy_q,    busy_d;
    logic             done_q,    done_d;

    logic [XLEN-1:0]  step_rem;
    logic [XLEN-1:0]  step_quo;
    logic             in_signed;

    div_unit_step u_step (
        .rem_in  (rem_q),
        .quo_in  (quo_q),
        .divisor (divisor_q),
        .rem_out (step_rem),
        .quo_out (step_quo)
    );

    // Next-state, datapath updates and output flags.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        divisor_d = divisor_q;
        q_neg_d   = q_neg_q;
        r_neg_d   = r_neg_q;
        cnt_d     = cnt_q;
        result_d  = result_q;
        in_signed = op_is_signed(bus.op);

        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    op_d      = bus.op;
                    q_neg_d   = bus.a[XLEN-1] ^ bus.b[XLEN-1];
                    r_neg_d   = bus.a[XLEN-1];
                    divisor_d = abs_if(bus.b, in_signed);
                    if (bus.b == ZERO_W) begin
                        result_d = op_is_quo(bus.op) ? ALL_ONES : bus.a;
                        state_d  = DONE;
                    end else if (in_signed && (bus.a == MIN_INT) &&
                                 (bus.b == ALL_ONES)) begin
                        result_d = op_is_quo(bus.op) ? bus.a : ZERO_W;
                        state_d  = DONE;
                    end else begin
                        rem_d   = ZERO_W;
                        quo_d   = abs_if(bus.a, in_signed);
                        cnt_d   = CNT_ZERO;
                        state_d = RUN;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                rem_d = step_rem;
                quo_d = step_quo;
                if (cnt_q == CNT_LAST) begin
                    state_d = FIX;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            FIX: begin
                case (op_q)
                    DIV:     result_d = q_neg_q ? -quo_q : quo_q;
                    DIVU:    result_d = quo_q;
                    REM:     result_d = r_neg_q ? -rem_q : rem_q;
                    REMU:    result_d = rem_q;
                    default: result_d = ZERO_W;
                endcase
                state_d = DONE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == RUN) || (state_d == FIX);
        done_d = (state_d == DONE);
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            op_q      <= DIV;
            rem_q     <= ZERO_W;
            quo_q     <= ZERO_W;
            divisor_q <= ZERO_W;
            q_neg_q   <= 1'b0;
            r_neg_q   <= 1'b0;
            cnt_q     <= CNT_ZERO;
            result_q  <= ZERO_W;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            divisor_q <= divisor_d;
            q_neg_q   <= q_neg_d;
            r_neg_q   <= r_neg_d;
            cnt_q     <= cnt_d;
            result_q  <= result_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;

endmodule

// File: tb/tb_div_unit.sv
// -----------------------------------------------------------------------------
// tb_div_unit
// Directed and random divider checks. Each request pushes its expected
// result and latency onto queues; they are popped when done is seen.
// -----------------------------------------------------------------------------
module tb_div_unit;
    import div_unit_pkg::*;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    div_unit_if dif ();

    div_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (dif)
    );

    int tests = 0;
    int fails = 0;

    logic [31:0] exp_res_q[$];
    int          exp_lat_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit is_special(input div_op_t op, input logic [31:0] a, input logic [31:0] b);
        return (b == 32'h0) ||
               ((op == DIV || op == REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    endfunction

    function automatic logic [31:0] ref_result(input div_op_t op, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        sa = a;
        sb = b;
        if (b == 32'h0) begin
            return (op == DIV || op == DIVU) ? 32'hFFFF_FFFF : a;
        end else if ((op == DIV || op == REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            return (op == DIV) ? a : 32'h0;
        end else begin
            case (op)
                DIV:     return sa / sb;
                REM:     return sa % sb;
                DIVU:    return a / b;
                REMU:    return a % b;
                default: return 32'hDEAD_BEEF;
            endcase
        end
    endfunction

    // Issue one request, wait for done (bounded), compare against the scoreboard.
    // If the divider is in DONE on entry this is a back-to-back accept.
    task automatic run_op(input string tag, input div_op_t op, input logic [31:0] a,
                          input logic [31:0] b, input bit poke_start);
        int          lat;
        logic [31:0] exp_res;
        int          exp_lat;
        exp_res_q.push_back(ref_result(op, a, b));
        exp_lat_q.push_back(is_special(op, a, b) ? 1 : 34);
        dif.op    = op;
        dif.a     = a;
        dif.b     = b;
        dif.start = 1'b1;
        @(posedge clk);
        #1;
        dif.start = 1'b0;
        // Operands may change after acceptance without affecting the result.
        dif.a     = $urandom;
        dif.b     = $urandom;
        dif.op    = (op == DIV) ? REMU : DIV;
        lat = 1;
        while (dif.done !== 1'b1 && lat < 100) begin
            if (poke_start && lat == 5) begin
                check({tag, " busy"}, {31'h0, dif.busy}, 32'h1);
                dif.start = 1'b1;
            end else begin
                dif.start = 1'b0;
            end
            @(posedge clk);
            #1;
            lat++;
        end
        dif.start = 1'b0;
        check({tag, " done seen"}, {31'h0, dif.done}, 32'h1);
        exp_res = exp_res_q.pop_front();
        exp_lat = exp_lat_q.pop_front();
        check({tag, " result"}, dif.result, exp_res);
        check({tag, " latency"}, lat, exp_lat);
    endtask

    // Idle cycles; done must drop right after its single-cycle pulse.
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (i == 0) begin
                check("done pulse width", {31'h0, dif.done}, 32'h0);
            end
        end
    endtask

    initial begin
        int          pulses;
        logic [1:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;

        reset     = 1'b1;
        dif.start = 1'b0;
        dif.op    = DIV;
        dif.a     = 32'h0;
        dif.b     = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check("reset busy",   {31'h0, dif.busy}, 32'h0);
        check("reset done",   {31'h0, dif.done}, 32'h0);
        check("reset result", dif.result,        32'h0);

        run_op("DIV -7/2",    DIV,  32'hFFFF_FFF9, 32'h2, 1'b0);
        idle(2);
        run_op("REM -7/2",    REM,  32'hFFFF_FFF9, 32'h2, 1'b0);
        run_op("DIVU max/2",  DIVU, 32'hFFFF_FFFF, 32'h2, 1'b0);
        run_op("REMU max/2",  REMU, 32'hFFFF_FFFF, 32'h2, 1'b0);
        idle(1);
        run_op("DIV 5/0",     DIV,  32'h5, 32'h0, 1'b0);
        run_op("REM 5/0",     REM,  32'h5, 32'h0, 1'b0);
        run_op("DIV ovf",     DIV,  32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run_op("REM ovf",     REM,  32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run_op("DIVU min/-1", DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run_op("REMU min/-1", REMU, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        idle(1);
        run_op("DIV 7/-2 poke", DIV, 32'h7, 32'hFFFF_FFFE, 1'b1);
        run_op("REM -7/-2",     REM, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 1'b0);
        run_op("DIV min/1",     DIV, 32'h8000_0000, 32'h1, 1'b0);
        run_op("REM min/3",     REM, 32'h8000_0000, 32'h3, 1'b0);
        run_op("DIVU 1/max",    DIVU, 32'h1, 32'hFFFF_FFFF, 1'b0);
        idle(1);

        for (int i = 0; i < 6; i++) begin
            rop = 2'($urandom_range(3, 0));
            ra  = $urandom;
            rb  = (i == 0) ? 32'h0 : ($urandom >> $urandom_range(31, 0));
            run_op($sformatf("rand%0d", i), div_op_t'(rop), ra, rb, 1'b0);
        end
        idle(1);

        // Abort mid-RUN: accept, then 10 step edges so the step counter is 10.
        dif.op    = DIV;
        dif.a     = 32'd100;
        dif.b     = 32'd3;
        dif.start = 1'b1;
        @(posedge clk);
        #1;
        dif.start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("pre-abort busy", {31'h0, dif.busy}, 32'h1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("abort busy",   {31'h0, dif.busy}, 32'h0);
        check("abort done",   {31'h0, dif.done}, 32'h0);
        check("abort result", dif.result,        32'h0);
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (dif.done === 1'b1) pulses++;
        end
        check("abort no done", pulses, 32'h0);

        run_op("DIVU after abort", DIVU, 32'd100, 32'd7, 1'b0);
        run_op("REMU b2b",         REMU, 32'd100, 32'd7, 1'b0);
        idle(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
